// File: rtl/bcd_display_ctrl_if.sv
// Board-side bundle for the BCD display controller: raw switch/key inputs,
// seven-segment outputs and conversion status.
interface bcd_display_ctrl_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] SW;
  logic             KEY0;
  logic [6:0]       HEX0;
  logic [6:0]       HEX1;
  logic [6:0]       HEX2;
  logic [6:0]       HEX3;
  logic             busy;
  logic             done;

  modport master (
    output SW, KEY0,
    input  HEX0, HEX1, HEX2, HEX3, busy, done
  );

  modport slave (
    input  SW, KEY0,
    output HEX0, HEX1, HEX2, HEX3, busy, done
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Debounced switch-to-decimal display controller: settles {KEY0,SW}, runs a
// serial double-dabble conversion and updates all four digits in one cycle.
module bcd_display_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SETTLE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_display_ctrl_if.slave  bus
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IT_W  = $clog2(WIDTH + 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [2:0] {IDLE, SETTLE, PREP, SHIFT, LATCH} state_t;

  state_t           state_q;
  logic [WIDTH:0]   sync1_q, sync2_q;
  logic [1:0]       primed_q;
  logic [WIDTH:0]   pending_q, last_q;
  logic             last_vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IT_W-1:0]  iter_q;
  logic [15:0]      bcd_q;
  logic [WIDTH-1:0] mag_q;
  logic             neg_q, uns_q;
  logic [6:0]       hex0_q, hex1_q, hex2_q, hex3_q;
  logic             busy_q, done_q;

  logic [15:0]      bcd_adj_d;
  logic [WIDTH:0]   neg_mag_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on every nibble ahead of the shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_add3
    assign bcd_adj_d[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                              : bcd_q[gi*4 +: 4];
  end

  // 11-bit two's-complement negate so -512 yields a magnitude of 512.
  assign neg_mag_d = {1'b0, ~pending_q[WIDTH-1:0]} + (WIDTH+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      primed_q   <= '0;
      pending_q  <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      cnt_q      <= '0;
      iter_q     <= '0;
      bcd_q      <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      uns_q      <= 1'b0;
      hex0_q     <= SEG_BLANK;
      hex1_q     <= SEG_BLANK;
      hex2_q     <= SEG_BLANK;
      hex3_q     <= SEG_BLANK;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync1_q  <= {bus.KEY0, bus.SW};
      sync2_q  <= sync1_q;
      primed_q <= {primed_q[0], 1'b1};
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // Wait until the synchroniser holds a real pin sample.
          if (primed_q[1] && (!last_vld_q || sync2_q != last_q)) begin
            pending_q <= sync2_q;
            cnt_q     <= '0;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2_q == pending_q) begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
              state_q <= PREP;
              busy_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (last_vld_q && sync2_q == last_q) begin
            // Glitch came back to the value already on display.
            state_q <= IDLE;
          end else begin
            pending_q <= sync2_q;
            cnt_q     <= '0;
          end
        end
        PREP: begin
          last_q     <= pending_q;
          last_vld_q <= 1'b1;
          uns_q      <= pending_q[WIDTH];
          if (!pending_q[WIDTH] && pending_q[WIDTH-1]) begin
            mag_q <= neg_mag_d[WIDTH-1:0];
            neg_q <= 1'b1;
          end else begin
            mag_q <= pending_q[WIDTH-1:0];
            neg_q <= 1'b0;
          end
          bcd_q   <= '0;
          iter_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= {bcd_adj_d[14:0], mag_q[WIDTH-1]};
          mag_q <= {mag_q[WIDTH-2:0], 1'b0};
          if (iter_q == IT_W'(WIDTH - 1)) begin
            state_q <= LATCH;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        LATCH: begin
          hex0_q  <= seg7(bcd_q[3:0]);
          hex1_q  <= seg7(bcd_q[7:4]);
          hex2_q  <= seg7(bcd_q[11:8]);
          hex3_q  <= uns_q ? seg7(bcd_q[15:12]) : (neg_q ? SEG_MINUS : SEG_BLANK);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;
  assign bus.HEX2 = hex2_q;
  assign bus.HEX3 = hex3_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
